layer5_result_reader: RTL and testbench

- Read-side sequencer for the layer-5 result store. On a start pulse it scans the two SIDE_DIM x SIDE_DIM halves of the store in row-major order and drives read_row_addr, read_col_addr, read_signal1 and read_signal2.
- The store applies the +5 side-2 offset internally.
- Each pair of words (side 1, side 2) is captured into an output register and streamed to the layer-6 consumer over a valid/ready handshake, with last and done markers.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/layer5_reader_out_reg.sv | 58 +++++
 rtl/layer5_result_reader.sv | 180 ++++++++++++++++++
 tb/tb_layer5_result_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the layer-5 result reader.
//   reader_state_t : read sequencer FSM states (IDLE, SCAN, DRAIN, DONE).
//   SIDE_DIM_DEF   : default rows/columns per store side (LAYER6_WIDTH/2).
//   ELEM_CNT       : elements per side (SIDE_DIM_DEF squared).
//   cnt_width()    : width of a 0..n-1 counter, never less than 1 bit.
// Fallback values for the project-wide width macros are defined here so
// the slice builds on its own.

`ifndef LAYER5_OUTPUT_LENGTH
`define LAYER5_OUTPUT_LENGTH 16
`endif
`ifndef LAYER6_WIDTH
`define LAYER6_WIDTH 10
`endif

package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  localparam int SIDE_DIM_DEF = `LAYER6_WIDTH / 2;
  localparam int ELEM_CNT     = SIDE_DIM_DEF * SIDE_DIM_DEF;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer5_reader_out_reg.sv
// layer5_reader_out_reg: output holding register for one (side1, side2)
// pair with its valid and last bits.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   i_load             : capture i_data1/i_data2/i_last this edge
//   i_data1, i_data2   : words to capture
//   i_last             : captured pair is the final element
//   i_ready            : consumer accepts the held pair
//   o_data1, o_data2   : held words
//   o_valid, o_last    : held pair is valid / is the final element
// A load always wins over acceptance; the top only loads when the slot
// is empty or being accepted in the same cycle. Data is held after
// acceptance, only valid and last drop.

module layer5_reader_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic              i_last,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic              o_valid,
  output logic              o_last
);

  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic              r_valid;
  logic              r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data1 <= '0;
      r_data2 <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data1 <= i_data1;
      r_data2 <= i_data2;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data1 = r_data1;
  assign o_data2 = r_data2;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/layer5_result_reader.sv
// layer5_result_reader: read-side sequencer for the layer-5 result store.
// A start pulse in IDLE scans both SIDE_DIM x SIDE_DIM halves in row-major
// order; each (side1, side2) pair is registered and streamed to layer 6.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   start                          : begin a scan (only honoured in IDLE)
//   read_row_addr, read_col_addr   : store address (held when not reading)
//   read_signal1, read_signal2     : store read enables
//   rd_data1, rd_data2             : same-cycle store read data
//   out_data1, out_data2           : registered pair
//   out_valid, out_ready, out_last : output handshake, final-element marker
//   busy, done                     : not IDLE / one-cycle end-of-scan pulse
//   stall_cycles                   : only with LAYER5_READER_STALL_CNT_EN
//   state_dbg                      : current FSM state
// Optional feature macro: LAYER5_READER_STALL_CNT_EN adds stall_cycles, a
// saturating count of SCAN/DRAIN cycles with out_valid=1 and out_ready=0.
//
// Handshake: a pair transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid rises, out_data1/2 and out_last stay
// stable until that transfer; the consumer may hold out_ready low freely.

`ifndef LAYER5_OUTPUT_LENGTH
`define LAYER5_OUTPUT_LENGTH 16
`endif

module layer5_result_reader
  import cnn_pkg::*;
#(
  parameter int DATA_W   = `LAYER5_OUTPUT_LENGTH,
  parameter int SIDE_DIM = SIDE_DIM_DEF,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic              read_signal1,
  output logic              read_signal2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output reader_state_t     state_dbg
`ifdef LAYER5_READER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int               CNT_W    = cnt_width(SIDE_DIM);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIDE_DIM - 1);

  reader_state_t    r_state;
  reader_state_t    w_next_state;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  // Address of the most recent read, presented while no read issues.
  logic [CNT_W-1:0] r_row_addr;
  logic [CNT_W-1:0] r_col_addr;
  logic             w_issue;
  logic             w_start_acc;
  logic             w_last_elem;

  assign w_last_elem = (r_row == LAST_IDX) && (r_col == LAST_IDX);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and issue decision. A read issues whenever the output slot
  // is empty or is being emptied this cycle, which gives one pair per
  // cycle under continuous out_ready.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_start_acc  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SCAN;
          w_start_acc  = 1'b1;
        end
      end
      SCAN: begin
        w_issue = !out_valid || out_ready;
        if (w_issue && w_last_elem) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_last && out_ready) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Row/column counters. Issuing the final element wraps both to 0, so
  // they never leave 0..SIDE_DIM-1.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_issue) begin
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_addr <= '0;
      r_col_addr <= '0;
    end else if (w_issue) begin
      r_row_addr <= r_row;
      r_col_addr <= r_col;
    end
  end

  assign read_row_addr = ADDR_W'(w_issue ? r_row : r_row_addr);
  assign read_col_addr = ADDR_W'(w_issue ? r_col : r_col_addr);
  assign read_signal1  = w_issue;
  assign read_signal2  = w_issue;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign state_dbg     = r_state;

  layer5_reader_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_issue),
    .i_data1 (rd_data1),
    .i_data2 (rd_data2),
    .i_last  (w_last_elem),
    .i_ready (out_ready),
    .o_data1 (out_data1),
    .o_data2 (out_data2),
    .o_valid (out_valid),
    .o_last  (out_last)
  );

`ifdef LAYER5_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_stall_cnt <= '0;
    end else if ((r_state == SCAN || r_state == DRAIN) && out_valid &&
                 !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_layer5_result_reader.sv
// tb_layer5_result_reader: bench for layer5_result_reader.
// Store model: side1[r][c] = 10r+c, side2[r][c] = 100+10r+c, returned
// combinationally while the read enable is high. Expected pairs are pushed
// into exp_q when a scan is launched and popped on every accepted transfer.

module tb_layer5_result_reader;
  import cnn_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int EW  = 2 * DW + 1;
  localparam int MAX = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] read_row_addr;
  logic [AW-1:0] read_col_addr;
  logic          read_signal1;
  logic          read_signal2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic [DW-1:0] out_data1;
  logic [DW-1:0] out_data2;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;
  reader_state_t state_dbg;
`ifdef LAYER5_READER_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_item;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  layer5_result_reader #(
    .DATA_W   (DW),
    .SIDE_DIM (5),
    .ADDR_W   (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .read_row_addr (read_row_addr),
    .read_col_addr (read_col_addr),
    .read_signal1  (read_signal1),
    .read_signal2  (read_signal2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .out_data1     (out_data1),
    .out_data2     (out_data2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
`ifdef LAYER5_READER_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  // Result store model.
  assign rd_data1 = read_signal1 ? DW'(32'(read_row_addr) * 10 + 32'(read_col_addr)) : '0;
  assign rd_data2 = read_signal2 ? DW'(100 + 32'(read_row_addr) * 10 + 32'(read_col_addr)) : '0;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected got pair d1=%0d d2=%0d last=%0d with no pair expected",
                 out_data1, out_data2, out_last);
      end else begin
        exp_item = exp_q.pop_front();
        if ({out_last, out_data1, out_data2} !== exp_item) begin
          n_bad++;
          $display("FAIL sb_pair got d1=%0d d2=%0d last=%0d expected d1=%0d d2=%0d last=%0d",
                   out_data1, out_data2, out_last,
                   exp_item[2*DW-1:DW], exp_item[DW-1:0], exp_item[2*DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_scan();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        logic lst;
        lst = (r == 4) && (c == 4);
        exp_q.push_back({lst, DW'(10 * r + c), DW'(100 + 10 * r + c)});
      end
    end
  endtask

  // One scan from IDLE. mode 0: out_ready=1; mode 1: out_ready 1,0,0,...;
  // mode 2: out_ready=1 plus start pulses after pairs 3 and 20;
  // mode 3: out_ready=1 except 0 for 5 cycles after the final issue.
  // Returns per-cycle observations; cycle 0 is the start cycle.
  task automatic run_scan(input int mode, output int first_issue, output int first_acc,
                          output int last_acc, output int done_cyc, output int n_acc,
                          output int n_stall, output int n_viol, output int n_hold,
                          output bit timed_out);
    int hold;
    bit prev_stall, stalled, s3, s20, pulse;
    logic [EW-1:0] prev;
    first_issue = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
    n_acc = 0; n_stall = 0; n_viol = 0; n_hold = 0;
    hold = 0; prev_stall = 0; s3 = 0; s20 = 0; prev = '0;
    for (int cyc = 0; cyc < MAX; cyc++) begin
      @(negedge clk);
      pulse = 0;
      if (mode == 2 && n_acc >= 3 && !s3) begin pulse = 1; s3 = 1; end
      else if (mode == 2 && n_acc >= 20 && !s20) begin pulse = 1; s20 = 1; end
      start = (cyc == 0) || pulse;
      if (mode == 1) out_ready = (cyc % 3 == 0);
      else if (mode == 3 && hold > 0) out_ready = 1'b0;
      else out_ready = 1'b1;
      #1;
      stalled = out_valid && !out_ready;
      if (busy && !done && stalled) n_stall++;
      if (read_signal1 !== read_signal2) n_viol++;
      if (stalled && read_signal1) n_viol++;
      if (prev_stall && (({out_last, out_data1, out_data2} !== prev) || !out_valid)) n_viol++;
      if (mode == 3 && hold > 0) begin
        if (busy && !done && out_valid && out_last) n_hold++;
        hold--;
      end
      if (read_signal1 && first_issue < 0) first_issue = cyc;
      if (mode == 3 && read_signal1 && read_row_addr == 16'd4 && read_col_addr == 16'd4) hold = 5;
      if (out_valid && out_ready) begin
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      prev_stall = stalled;
      prev = {out_last, out_data1, out_data2};
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    timed_out = (done_cyc < 0);
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [AW-1:0] got[11];
    string nm[11];
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    got[0] = AW'(out_valid);    nm[0] = "out_valid";
    got[1] = AW'(out_last);     nm[1] = "out_last";
    got[2] = AW'(out_data1);    nm[2] = "out_data1";
    got[3] = AW'(out_data2);    nm[3] = "out_data2";
    got[4] = AW'(busy);         nm[4] = "busy";
    got[5] = AW'(done);         nm[5] = "done";
    got[6] = AW'(read_signal1); nm[6] = "read_signal1";
    got[7] = AW'(read_signal2); nm[7] = "read_signal2";
    got[8] = read_row_addr;     nm[8] = "read_row_addr";
    got[9] = read_col_addr;     nm[9] = "read_col_addr";
`ifdef LAYER5_READER_STALL_CNT_EN
    got[10] = stall_cycles;     nm[10] = "stall_cycles";
`else
    got[10] = AW'(state_dbg);   nm[10] = "state_dbg";
`endif
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (got[i] !== '0) begin
        n_bad++;
        $display("FAIL reset_%s got %0d expected 0", nm[i], got[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_ready();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    push_scan();
    run_scan(0, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (to)     begin n_bad++; $display("FAIL full_timeout got done never expected done"); end
    n_cmp++; if (fi != 1)  begin n_bad++; $display("FAIL full_first_issue got %0d expected 1", fi); end
    n_cmp++; if (fa != 2)  begin n_bad++; $display("FAIL full_first_acc got %0d expected 2", fa); end
    n_cmp++; if (la != 26) begin n_bad++; $display("FAIL full_last_acc got %0d expected 26", la); end
    n_cmp++; if (dc != 27) begin n_bad++; $display("FAIL full_done_cyc got %0d expected 27", dc); end
    n_cmp++; if (na != 25) begin n_bad++; $display("FAIL full_pairs got %0d expected 25", na); end
    n_cmp++; if (nv != 0)  begin n_bad++; $display("FAIL full_protocol got %0d violations expected 0", nv); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_leftover got %0d expected 0", exp_q.size()); end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL full_done_width got done=%0d busy=%0d expected 0 0", done, busy);
    end
  endtask

  task automatic test_ready_toggle();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    push_scan();
    run_scan(1, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (to)      begin n_bad++; $display("FAIL toggle_timeout got done never expected done"); end
    n_cmp++; if (na != 25) begin n_bad++; $display("FAIL toggle_pairs got %0d expected 25", na); end
    n_cmp++; if (nv != 0)  begin n_bad++; $display("FAIL toggle_stall_protocol got %0d violations expected 0", nv); end
    n_cmp++; if (ns < 20)  begin n_bad++; $display("FAIL toggle_stalls got %0d expected at least 20", ns); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL toggle_leftover got %0d expected 0", exp_q.size()); end
`ifdef LAYER5_READER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 16'(ns)) begin
      n_bad++; $display("FAIL toggle_stall_cycles got %0d expected %0d", stall_cycles, ns);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    @(negedge clk);
    push_scan();
    run_scan(2, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (to)       begin n_bad++; $display("FAIL restart_timeout got done never expected done"); end
    n_cmp++; if (na != 25) begin n_bad++; $display("FAIL restart_pairs got %0d expected 25", na); end
    n_cmp++; if (dc != 27) begin n_bad++; $display("FAIL restart_done_cyc got %0d expected 27", dc); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL restart_leftover got %0d expected 0", exp_q.size()); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_idle got busy=%0d expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int acc, guard;
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    push_scan();
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    acc = 0; guard = 0;
    while (acc < 12 && guard < 60) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) acc++;
      guard++;
    end
    n_cmp++; if (acc != 12) begin n_bad++; $display("FAIL rstmid_reach got %0d pairs expected 12", acc); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %0d expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0d expected 0", busy); end
    n_cmp++; if (read_row_addr !== '0 || read_col_addr !== '0) begin
      n_bad++; $display("FAIL rstmid_addr got row=%0d col=%0d expected 0 0", read_row_addr, read_col_addr);
    end
    n_cmp++; if (exp_q.size() != 13) begin n_bad++; $display("FAIL rstmid_remaining got %0d expected 13", exp_q.size()); end
    exp_q.delete();
    push_scan();
    run_scan(0, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (na != 25 || dc != 27) begin
      n_bad++; $display("FAIL rstmid_rescan got pairs=%0d done_cyc=%0d expected 25 27", na, dc);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rstmid_leftover got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_drain_hold();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    @(negedge clk);
    push_scan();
    run_scan(3, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (nh != 5)  begin n_bad++; $display("FAIL drain_hold got %0d held cycles expected 5", nh); end
    n_cmp++; if (la != 31) begin n_bad++; $display("FAIL drain_last_acc got %0d expected 31", la); end
    n_cmp++; if (dc != 32) begin n_bad++; $display("FAIL drain_done_cyc got %0d expected 32", dc); end
    n_cmp++; if (nv != 0)  begin n_bad++; $display("FAIL drain_protocol got %0d violations expected 0", nv); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL drain_leftover got %0d expected 0", exp_q.size()); end
`ifdef LAYER5_READER_STALL_CNT_EN
    n_cmp++; if (stall_cycles !== 16'd5) begin n_bad++; $display("FAIL drain_stall_cycles got %0d expected 5", stall_cycles); end
`endif
  endtask

  task automatic test_done_start();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    @(negedge clk);
    push_scan();
    run_scan(0, fi, fa, la, dc, na, ns, nv, nh, to);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL done_start got busy=%0d expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int fi, fa, la, dc, na, ns, nv, nh;
    bit to;
    @(negedge clk);
    push_scan();
    run_scan(0, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (na != 25) begin n_bad++; $display("FAIL b2b_first_pairs got %0d expected 25", na); end
    push_scan();
    run_scan(0, fi, fa, la, dc, na, ns, nv, nh, to);
    n_cmp++; if (na != 25 || dc != 27) begin
      n_bad++; $display("FAIL b2b_second got pairs=%0d done_cyc=%0d expected 25 27", na, dc);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_leftover got %0d expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_ready();
    test_ready_toggle();
    test_start_ignored();
    test_reset_mid();
    test_drain_hold();
    test_done_start();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
